bin2bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using iterative shift-and-add-3 (double dabble).
- Sits directly downstream of the CPU datapath: it consumes a binary value (PC or register write-back data) and produces packed decimal digits for the seg7 display decoders.
- It replaces the combinational divide/modulo chains feeding the displays, taking one bit per clock.

---
 rtl/bin2bcd_seq_pkg.sv | 19 +
 rtl/bin2bcd_seq_add3.sv | 10 +
 rtl/bin2bcd_seq.sv | 113 +++++++++++
 tb/tb_bin2bcd_seq.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and sizing for the sequential binary-to-BCD converter.
// Defaults match the CPU top: 32-bit values shown on ten digits.
package bin2bcd_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam int WIDTH_DEF  = 32;
  localparam int DIGITS_DEF = 10;

  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cnt_w(WIDTH_DEF);

endpackage

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble digit adjuster: a digit of 5 or more gets +3.
// The result stays 4 bits wide; legal digits never exceed 12.
module bcd_add3 (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  assign o_digit = (i_digit >= 4'd5) ? i_digit + 4'd3 : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one input bit per clock.
// Feeds packed digits to the seg7 display decoders.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int CW = cnt_w(WIDTH);
  localparam int BW = 4 * DIGITS;

  state_t            r_state;
  state_t            w_next;
  logic              w_load;
  logic              w_fin;
  logic [WIDTH-1:0]  r_shift;
  logic [BW-1:0]     r_acc;
  logic [CW-1:0]     r_cnt;
  logic              r_ovf_st;
  logic [BW-1:0]     r_bcd;
  logic              r_ovf;
  logic              r_done;
  logic [BW-1:0]     w_adj;
  logic [BW-1:0]     w_acc_nx;
  logic              w_ovf_nx;
  logic              w_last;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_add3 u_add3 (
      .i_digit (r_acc[4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  // The bit leaving the top digit is worth 10^DIGITS: overflow.
  assign w_acc_nx = {w_adj[BW-2:0], r_shift[WIDTH-1]};
  assign w_ovf_nx = r_ovf_st | w_adj[BW-1];
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_fin  = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = CONV;
        end
      end
      CONV: begin
        if (w_last) begin
          w_fin  = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_ovf_st <= 1'b0;
      r_bcd    <= '0;
      r_ovf    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_load) begin
        r_shift  <= bin_in;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_ovf_st <= 1'b0;
      end else if (r_state == CONV) begin
        r_shift  <= {r_shift[WIDTH-2:0], 1'b0};
        r_acc    <= w_acc_nx;
        r_cnt    <= r_cnt + CW'(1);
        r_ovf_st <= w_ovf_nx;
      end
      if (w_fin) begin
        r_bcd <= w_acc_nx;
        r_ovf <= w_ovf_nx;
      end
    end
  end

  assign busy    = (r_state == CONV);
  assign done    = r_done;
  assign bcd_out = r_bcd;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: ten-digit and four-digit
// instances share the stimulus and are checked side by side.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] bin_in = '0;
  logic        busy, done, ovf;
  logic [39:0] bcd_out;
  logic        s_busy, s_done, s_ovf;
  logic [15:0] s_bcd;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bin2bcd_seq #(.WIDTH(32), .DIGITS(10)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf)
  );

  bin2bcd_seq #(.WIDTH(32), .DIGITS(4)) u_dut4 (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (s_busy),
    .done    (s_done),
    .bcd_out (s_bcd),
    .ovf     (s_ovf)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_conv(input logic [31:0] v,
                          output int lat, output int bz);
    start  = 1'b1;
    bin_in = v;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bz  = 0;
    while (!done && lat < 100) begin
      bz += int'(busy);
      @(negedge clk);
      lat++;
    end
  endtask

  int lat, bz, ndone;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_bcd", 64'(bcd_out), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_bcd4", 64'(s_bcd), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_conv(32'd0, lat, bz);
    chk("zero_lat", 64'(lat), 64'd32);
    chk("zero_busy", 64'(bz), 64'd32);
    chk("zero_bcd", 64'(bcd_out), 64'd0);
    chk("zero_ovf", 64'(ovf), 64'd0);
    chk("zero_nbusy", 64'(busy), 64'd0);
    @(negedge clk);
    chk("zero_pulse", 64'(done), 64'd0);

    run_conv(32'hFFFF_FFFF, lat, bz);
    chk("max_lat", 64'(lat), 64'd32);
    chk("max_bcd", 64'(bcd_out), 64'h42_9496_7295);
    chk("max_ovf", 64'(ovf), 64'd0);
    chk("max_bcd4", 64'(s_bcd), 64'h7295);
    chk("max_ovf4", 64'(s_ovf), 64'd1);
    @(negedge clk);

    run_conv(32'd1234, lat, bz);
    chk("d4_1234_bcd", 64'(s_bcd), 64'h1234);
    chk("d4_1234_ovf", 64'(s_ovf), 64'd0);
    chk("d10_1234", 64'(bcd_out), 64'h1234);
    @(negedge clk);

    run_conv(32'd10000, lat, bz);
    chk("d4_10k_bcd", 64'(s_bcd), 64'h0);
    chk("d4_10k_ovf", 64'(s_ovf), 64'd1);
    chk("d10_10k", 64'(bcd_out), 64'h10000);
    chk("d10_10k_ovf", 64'(ovf), 64'd0);
    @(negedge clk);

    // start while busy, with bin_in changed, must be ignored
    start  = 1'b1;
    bin_in = 32'd57;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start  = 1'b1;
    bin_in = 32'd99;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("ign_lat", 64'(lat), 64'd22);
    chk("ign_bcd", 64'(bcd_out), 64'h57);
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      ndone += int'(done);
    end
    chk("ign_ndone", 64'(ndone), 64'd0);
    chk("ign_busy", 64'(busy), 64'd0);

    // start held high: accepted again in each done cycle
    start  = 1'b1;
    bin_in = 32'd7;
    @(negedge clk);
    bin_in = 32'd42;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("bb0_lat", 64'(lat), 64'd33);
    chk("bb0_bcd", 64'(bcd_out), 64'h7);
    @(negedge clk);
    bin_in = 32'd7;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("bb1_lat", 64'(lat), 64'd33);
    chk("bb1_bcd", 64'(bcd_out), 64'h42);
    @(negedge clk);
    bin_in = 32'd42;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("bb2_lat", 64'(lat), 64'd33);
    chk("bb2_bcd", 64'(bcd_out), 64'h7);
    @(negedge clk);

    // reset mid-conversion aborts and clears the result
    start  = 1'b1;
    bin_in = 32'd4321;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_bcd", 64'(bcd_out), 64'd0);
    chk("abort_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    ndone = 0;
    repeat (30) begin
      @(negedge clk);
      ndone += int'(done);
    end
    chk("abort_ndone", 64'(ndone), 64'd0);

    run_conv(32'd305, lat, bz);
    chk("post_lat", 64'(lat), 64'd32);
    chk("post_bcd", 64'(bcd_out), 64'h305);
    chk("post_bcd4", 64'(s_bcd), 64'h0305);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
